// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - parametrised up/down modulo counter with prescaler, wrap/saturate, tc/ovf/match
module counter_mod #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAXVAL   = {WIDTH{1'b1}},
  parameter int               SATURATE = 0,
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc;
  logic             step;
  logic             at_top;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] ld_clip;
  logic [WIDTH-1:0] step_val;

  assign step     = en && (psc == PS_LAST);
  assign at_top   = (count == MAXVAL);
  assign at_zero  = (count == '0);
  assign boundary = up ? at_top : at_zero;
  assign ld_clip  = (ld_val > MAXVAL) ? MAXVAL : ld_val;
  assign match    = (count == cmp_val);

  // Boundaries are tested before arithmetic so no value ever leaves WIDTH bits.
  always_comb begin
    step_val = count;
    if (up) begin
      if (!at_top)
        step_val = count + WIDTH'(1);
      else if (SATURATE == 0)
        step_val = '0;
    end else begin
      if (!at_zero)
        step_val = count - WIDTH'(1);
      else if (SATURATE == 0)
        step_val = MAXVAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      psc   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= ld_clip;
      psc   <= '0;
      tc    <= 1'b0;
    end else if (step) begin
      count <= step_val;
      psc   <= '0;
      tc    <= boundary;
      if (boundary)
        ovf <= 1'b1;
    end else begin
      tc <= 1'b0;
      if (en)
        psc <= psc + PW'(1);
    end
  end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised up/down modulo counter, the general-purpose successor to the fixed 32-bit free-running counter. It has a programmable width and modulus, wrap or saturate mode, a clock-enable prescaler, synchronous clear and load, and terminal-count, sticky-overflow and compare outputs. It sits beside datapath blocks as a timebase, event counter or address generator.

## Interface
Parameters:
- WIDTH, 32: counter width in bits (≥2).
- MAXVAL, 2**WIDTH-1: terminal value; count range is 0..MAXVAL.
- SATURATE, 0: 0 = wrap at boundaries, 1 = hold at boundaries.
- PRESCALE, 1: number of enabled cycles per count step (≥1).

Ports (clock and reset first):
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of ld_val.
- ld_val  in  WIDTH  load value.
- en  in  1  count enable; feeds the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- cmp_val  in  WIDTH  compare value.
- count  out  WIDTH  current count (registered).
- tc  out  1  one-cycle terminal-count pulse (registered).
- ovf  out  1  sticky boundary flag (registered).
- match  out  1  count == cmp_val (combinational from count).

## Operation
- Reset (rst=1): count=0, tc=0, ovf=0, prescaler=0, immediately and regardless of clk.
- Per-edge priority is clr > load > step > hold.
- clr: count=0, prescaler=0, ovf=0, tc=0.
- load: count=min(ld_val, MAXVAL), prescaler=0, tc=0, ovf unchanged.
- Prescaler:
  - An internal counter 0..PRESCALE-1 advances only when en=1.
  - A step occurs on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - PRESCALE=1 means every enabled cycle is a step.
  - en=0 freezes the prescaler and count.
- Up step:
  - If count<MAXVAL: count+1.
  - If count==MAXVAL: count=0 (SATURATE=0) or count held at MAXVAL (SATURATE=1). In both cases this is a boundary event.
- Down step:
  - If count>0: count-1.
  - If count==0: count=MAXVAL (SATURATE=0) or count held at 0 (SATURATE=1). In both cases this is a boundary event.
- Boundary event: tc=1 for exactly the next cycle, and ovf is set. tc is 0 on every other cycle.
- With SATURATE=1 and en held at a boundary, every step is a boundary event, so tc pulses once per step.
- up may change on any cycle; it takes effect on the next step. The prescaler phase is not disturbed.
- Arithmetic is unsigned, modulo MAXVAL+1. No intermediate value exceeds WIDTH bits; compare before incrementing.

## Timing
- count, tc and ovf update one clock after the qualifying edge inputs.
- Latency from en=1 to count change is PRESCALE cycles, measured from a zero prescaler phase.
- tc is asserted in the same cycle count shows the wrapped or held value.
- match follows count combinationally, with no added latency.
- clr or load in the same cycle as a step: the step is discarded and the clr/load result is taken.
- Reset asserted mid-count: outputs go to reset values asynchronously. After reset deasserts, counting resumes on the first edge with en=1, and the first step occurs PRESCALE enabled cycles later.

## Test plan
- Reset/free-run: WIDTH=4, MAXVAL=15, PRESCALE=1, SATURATE=0, en=1, up=1.
  - count runs 0..15, then 0.
  - tc is high for exactly the cycle count==0 after 15.
  - ovf=1 from then on.
- Modulus and down-count: MAXVAL=9, up=0 from count=0.
  - Next step gives count=9, tc=1, ovf=1.
  - Further steps give 8, 7, … with tc=0.
- Saturate: SATURATE=1, MAXVAL=9, load 9, up=1, en=1 for 3 cycles.
  - count stays 9, with tc pulsing each step.
  - Switching to up=0 gives 8, 7, …
- Prescaler: PRESCALE=3, en=1 continuously from count=0.
  - count increments every 3rd cycle.
  - en dropped for 2 cycles mid-phase delays the next step by exactly 2 cycles.
- Priority/edges:
  - clr and load together give count=0, ovf=0.
  - load ld_val=12 with MAXVAL=9 gives count=9.
  - A step coinciding with load gives count=ld_val.
  - Async rst mid-count gives count=0 before the next clk edge.
- Compare: cmp_val=5, counting up from 0. match is high only while count==5.
